modular_mul_iter: RTL

- Area-reduced, parametrised successor to the fully unrolled Montgomery multiplier.
- Uses one radix-2 bit-serial Montgomery engine, reused over W iterations per pass, to compute several modular operations.
- Selectable operating mode.
- Valid/ready handshakes on both sides, so it drops into streaming NTT/poly-mul datapaths where throughput per multiplier is traded for area.

---
 rtl/modular_mul_iter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/modular_mul_iter.sv
// Iterative radix-2 Montgomery multiplier. One bit-serial engine is reused for
// A*B mod M, mont(A,B), and conversions into/out of the Montgomery domain.
module modular_mul_iter #(
  parameter int                    data_width = 256,
  parameter logic [data_width-1:0] M  = 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
  parameter logic [data_width-1:0] R2 = 256'h0748d9d99f59ff1105d314967254398f2b6cedcb87925c23c999e990f3f29c6d
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [data_width-1:0] A_in,
  input  logic [data_width-1:0] B_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] P_out,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int TW = data_width + 2;
  localparam int CW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] LAST = CW'(data_width - 1);

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t                  state, state_nx;
  logic [1:0]              mode_r;
  logic                    first_r;
  logic [data_width-1:0]   x_r, y_r, p_r, y_load, t_corr;
  logic [TW-1:0]           t_r, t_sum, t_odd, t_step;
  logic [CW-1:0]           i_r;
  logic                    t_ge_m, last_pass;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE and out_valid only in DONE, so the
  // block never accepts a new job on the edge that drains a result.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ITER) || (state == CORR);
  assign P_out     = p_r;
  assign state_dbg = state;

  // Second operand of the (first) pass depends on the operation.
  always_comb begin
    y_load = B_in;
    case (mode)
      2'd2:    y_load = R2;
      2'd3:    y_load = data_width'(1);
      default: y_load = B_in;
    endcase
  end

  // One Montgomery step: add a_i*Y, make even with M, halve.
  assign t_sum     = t_r + (x_r[0] ? {2'b00, y_r} : '0);
  assign t_odd     = t_sum + (t_sum[0] ? {2'b00, M} : '0);
  assign t_step    = t_odd >> 1;
  assign t_ge_m    = (t_r >= {2'b00, M});
  assign t_corr    = data_width'(t_ge_m ? t_r - {2'b00, M} : t_r);
  assign last_pass = (mode_r != 2'd0) || !first_r;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = ITER;
      ITER:    if (i_r == LAST) state_nx = CORR;
      CORR:    state_nx = last_pass ? DONE : ITER;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r  <= '0;
      first_r <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      t_r     <= '0;
      i_r     <= '0;
      p_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_r  <= mode;
            first_r <= 1'b1;
            x_r     <= A_in;
            y_r     <= y_load;
            t_r     <= '0;
            i_r     <= '0;
          end
        end
        ITER: begin
          t_r <= t_step;
          x_r <= x_r >> 1;
          i_r <= i_r + 1'b1;
        end
        CORR: begin
          i_r <= '0;
          if (!last_pass) begin
            // Mode 0 second pass: multiply by R^2 to leave the Montgomery domain.
            x_r     <= t_corr;
            y_r     <= R2;
            t_r     <= '0;
            first_r <= 1'b0;
          end else begin
            p_r <= t_corr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
